traffic_phase_controller: RTL and testbench

- Parametrised successor to the single-intersection traffic light FSM.
- Drives NUM_PHASES signal groups in rotation, and folds the interval timer into the block, replacing the external expired/start_timer handshake.
- Adds per-phase sensor demand with phase skipping, a one-shot green extension, a pedestrian walk phase, runtime-programmable intervals and a flashing fault mode.
- Sits between the input synchronisers and the lamp drivers.

---
 rtl/traffic_phase_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// Multi-phase traffic signal controller with an internal interval timer.
// Serves NUM_PHASES signal groups in rotation. Phase 0 is always served;
// other phases are served only if a vehicle was sensed. The block also
// grants one green extension, inserts a pedestrian walk phase, holds
// runtime-programmable intervals and has a flashing-yellow fault mode.
module traffic_phase_controller #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  parameter int T_BASE_DEF = 6,
  parameter int T_EXT_DEF  = 3,
  parameter int T_YEL_DEF  = 2,
  parameter int T_WALK_DEF = 7
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          tick,
  input  logic [NUM_PHASES-1:0]         sensor,
  input  logic                          walk_req,
  input  logic                          prog,
  input  logic [1:0]                    prog_sel,
  input  logic [CNT_W-1:0]              prog_val,
  input  logic                          flash_mode,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic                          walk,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx
);

  localparam int               PW      = $clog2(NUM_PHASES);
  localparam logic [PW-1:0]    LAST_PH = PW'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_ALL_RED, S_SELECT, S_GREEN, S_GREEN_EXT, S_YELLOW, S_WALK, S_FLASH
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    flash_q, flash_d;
  logic                    ext_used_q, ext_used_d;
  logic                    walk_pending_q, walk_pending_d;
  logic [NUM_PHASES-1:0]   demand_q, demand_d;
  logic [CNT_W-1:0]        t_base_q, t_base_d;
  logic [CNT_W-1:0]        t_ext_q, t_ext_d;
  logic [CNT_W-1:0]        t_yel_q, t_yel_d;
  logic [CNT_W-1:0]        t_walk_q, t_walk_d;
  logic [NUM_PHASES-1:0]   green_q, green_d;
  logic [NUM_PHASES-1:0]   yellow_q, yellow_d;
  logic [NUM_PHASES-1:0]   red_q, red_d;
  logic                    walk_q, walk_d;

  logic [PW-1:0]           next_ph;
  logic [NUM_PHASES-1:0]   dem_set, dem_clr;
  logic                    walk_clr;
  logic                    expire;

  // A programmed interval of zero still has to last one tick.
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  // Interval register writes; a write only matters at the next timer load.
  always_comb begin
    t_base_d = t_base_q;
    t_ext_d  = t_ext_q;
    t_yel_d  = t_yel_q;
    t_walk_d = t_walk_q;
    if (prog) begin
      case (prog_sel)
        2'd0:    t_base_d = prog_val;
        2'd1:    t_ext_d  = prog_val;
        2'd2:    t_yel_d  = prog_val;
        default: t_walk_d = prog_val;
      endcase
    end
  end

  // Next-state, timer, demand and walk bookkeeping.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    flash_d    = flash_q;
    ext_used_d = ext_used_q;
    dem_clr    = '0;
    walk_clr   = 1'b0;
    next_ph    = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
    // the phase being served cannot re-request itself while it is green
    dem_set    = sensor;
    if (state_q == S_GREEN || state_q == S_GREEN_EXT)
      dem_set = sensor & ~(NUM_PHASES'(1) << phase_q);
    expire     = tick && (cnt_q == ONE);

    if (flash_mode) begin
      if (state_q != S_FLASH) begin
        state_d = S_FLASH;
        flash_d = 1'b0;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end else begin
      if (tick && state_q != S_SELECT && state_q != S_FLASH)
        cnt_d = cnt_q - ONE;
      case (state_q)
        S_ALL_RED: if (expire) begin
          if (walk_pending_q) begin
            state_d  = S_WALK;
            cnt_d    = ld(t_walk_q);
            walk_clr = 1'b1;
          end else begin
            state_d = S_SELECT;
          end
        end
        S_WALK: if (expire) state_d = S_SELECT;
        S_SELECT: begin
          phase_d = next_ph;
          if (next_ph == '0 || demand_q[next_ph]) begin
            state_d    = S_GREEN;
            cnt_d      = ld(t_base_q);
            ext_used_d = 1'b0;
            dem_clr    = NUM_PHASES'(1) << next_ph;
          end
        end
        S_GREEN: if (expire) begin
          if (sensor[phase_q] && !ext_used_q) begin
            state_d    = S_GREEN_EXT;
            cnt_d      = ld(t_ext_q);
            ext_used_d = 1'b1;
          end else begin
            state_d = S_YELLOW;
            cnt_d   = ld(t_yel_q);
          end
        end
        S_GREEN_EXT: if (expire) begin
          state_d = S_YELLOW;
          cnt_d   = ld(t_yel_q);
        end
        S_YELLOW: if (expire) begin
          state_d = S_ALL_RED;
          cnt_d   = ONE;
        end
        default: begin
          // leaving flash (or an illegal encoding) restarts the rotation at phase 0
          state_d = S_ALL_RED;
          phase_d = LAST_PH;
          cnt_d   = ONE;
        end
      endcase
    end

    demand_d       = (demand_q | dem_set) & ~dem_clr;
    walk_pending_d = (walk_pending_q & ~walk_clr) | walk_req;
  end

  // Lamp decode from the next state so the lamp flops mirror the state flops.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
    walk_d   = 1'b0;
    case (state_d)
      S_GREEN, S_GREEN_EXT: begin
        green_d = NUM_PHASES'(1) << phase_d;
        red_d   = ~green_d;
      end
      S_YELLOW: begin
        yellow_d = NUM_PHASES'(1) << phase_d;
        red_d    = ~yellow_d;
      end
      S_WALK:  walk_d = 1'b1;
      S_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_PHASES{flash_d}};
      end
      default: ;
    endcase
  end

  // All state, interval and lamp registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_ALL_RED;
      phase_q        <= LAST_PH;
      cnt_q          <= ONE;
      flash_q        <= 1'b0;
      ext_used_q     <= 1'b0;
      walk_pending_q <= 1'b0;
      demand_q       <= '0;
      t_base_q       <= CNT_W'(T_BASE_DEF);
      t_ext_q        <= CNT_W'(T_EXT_DEF);
      t_yel_q        <= CNT_W'(T_YEL_DEF);
      t_walk_q       <= CNT_W'(T_WALK_DEF);
      green_q        <= '0;
      yellow_q       <= '0;
      red_q          <= '1;
      walk_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      flash_q        <= flash_d;
      ext_used_q     <= ext_used_d;
      walk_pending_q <= walk_pending_d;
      demand_q       <= demand_d;
      t_base_q       <= t_base_d;
      t_ext_q        <= t_ext_d;
      t_yel_q        <= t_yel_d;
      t_walk_q       <= t_walk_d;
      green_q        <= green_d;
      yellow_q       <= yellow_d;
      red_q          <= red_d;
      walk_q         <= walk_d;
    end
  end

  assign green     = green_q;
  assign yellow    = yellow_q;
  assign red       = red_q;
  assign walk      = walk_q;
  assign phase_idx = phase_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller. Inputs are driven on the falling
// edge; a reference model computes the lamps expected after the next rising
// edge and queues them. A monitor pops and compares after every rising edge.
module tb_traffic_phase_controller;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int CW = 8;
  localparam int M_AR = 0, M_SEL = 1, M_GRN = 2, M_EXT = 3, M_YEL = 4, M_WALK = 5, M_FL = 6;

  logic          clock = 1'b0, reset_n = 1'b0, tick = 1'b0;
  logic          walk_req = 1'b0, prog = 1'b0, flash_mode = 1'b0;
  logic [NP-1:0] sensor = '0;
  logic [1:0]    prog_sel = '0;
  logic [CW-1:0] prog_val = '0;
  logic [NP-1:0] green, yellow, red;
  logic          walk;
  logic [PW-1:0] phase_idx;

  traffic_phase_controller #(
    .NUM_PHASES(NP), .CNT_W(CW), .T_BASE_DEF(6), .T_EXT_DEF(3), .T_YEL_DEF(2), .T_WALK_DEF(7)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .sensor(sensor), .walk_req(walk_req),
    .prog(prog), .prog_sel(prog_sel), .prog_val(prog_val), .flash_mode(flash_mode),
    .green(green), .yellow(yellow), .red(red), .walk(walk), .phase_idx(phase_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NP-1:0] g, y, r;
    logic          w;
    logic [PW-1:0] ph;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode, ticks left in the mode, pending requests.
  int            m_st, m_ph, m_left;
  bit            m_fb, m_ext, m_wp;
  bit [NP-1:0]   m_dem;
  int            ivl[4];

  function automatic int iv(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_st = M_AR; m_ph = NP - 1; m_left = 1;
    m_fb = 0; m_ext = 0; m_wp = 0; m_dem = '0;
    ivl[0] = 6; ivl[1] = 3; ivl[2] = 2; ivl[3] = 7;
  endtask

  task automatic model_step();
    bit [NP-1:0] set_v, new_dem;
    bit          wclr;
    wclr = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    set_v = sensor;
    if (m_st == M_GRN || m_st == M_EXT) set_v[m_ph] = 0;
    new_dem = m_dem | set_v;
    if (flash_mode) begin
      if (m_st != M_FL) begin m_st = M_FL; m_fb = 0; end
      else if (tick) m_fb = ~m_fb;
    end else if (m_st == M_FL) begin
      m_st = M_AR; m_ph = NP - 1; m_left = 1;
    end else if (m_st == M_SEL) begin
      m_ph = (m_ph + 1) % NP;
      if (m_ph == 0 || m_dem[m_ph]) begin
        m_st = M_GRN; m_left = iv(ivl[0]); m_ext = 0; new_dem[m_ph] = 0;
      end
    end else if (tick) begin
      m_left--;
      if (m_left == 0) begin
        case (m_st)
          M_AR:   if (m_wp) begin m_st = M_WALK; m_left = iv(ivl[3]); wclr = 1; end
                  else m_st = M_SEL;
          M_WALK: m_st = M_SEL;
          M_GRN:  if (sensor[m_ph] && !m_ext) begin m_st = M_EXT; m_left = iv(ivl[1]); m_ext = 1; end
                  else begin m_st = M_YEL; m_left = iv(ivl[2]); end
          M_EXT:  begin m_st = M_YEL; m_left = iv(ivl[2]); end
          default: begin m_st = M_AR; m_left = 1; end
        endcase
      end
    end
    m_dem = new_dem;
    m_wp  = (m_wp && !wclr) || walk_req;
    if (prog) ivl[prog_sel] = int'(prog_val);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g = '0; e.y = '0; e.r = '1; e.w = 1'b0; e.ph = PW'(m_ph);
    case (m_st)
      M_GRN, M_EXT: begin e.g[m_ph] = 1'b1; e.r[m_ph] = 1'b0; end
      M_YEL:        begin e.y[m_ph] = 1'b1; e.r[m_ph] = 1'b0; end
      M_WALK:       e.w = 1'b1;
      M_FL:         begin e.r = '0; e.y = {NP{m_fb}}; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock: predict, queue, advance to the next falling edge.
  task automatic cyc();
    model_step();
    sb_q.push_back(model_out());
    @(negedge clock);
  endtask

  function automatic logic lamp(input int kind, input int p);
    case (kind)
      0:       return green[p];
      1:       return yellow[p];
      default: return walk;
    endcase
  endfunction

  task automatic wait_lamp(input int kind, input int p, input string nm);
    int n = 0;
    while (!lamp(kind, p) && n < 300) begin cyc(); n++; end
    check({nm, "_reached"}, 32'(lamp(kind, p)), 32'd1);
  endtask

  task automatic count_lamp(input int kind, input int p, input int exp, input string nm);
    int n = 0;
    while (lamp(kind, p) && n < 300) begin cyc(); n++; end
    check(nm, n, exp);
  endtask

  // Monitor: compares whatever the model queued for this edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("green",     32'(green),     32'(e.g));
        check("yellow",    32'(yellow),    32'(e.y));
        check("red",       32'(red),       32'(e.r));
        check("walk",      32'(walk),      32'(e.w));
        check("phase_idx", 32'(phase_idx), 32'(e.ph));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    tick = 1'b1;
    @(negedge clock);
    repeat (3) cyc();
    reset_n = 1'b1;

    // default rotation, only phase 0 served
    wait_lamp(0, 0, "p0_first");
    count_lamp(0, 0, 6, "p0_green_len");
    count_lamp(1, 0, 2, "p0_yellow_len");
    repeat (10) cyc();

    // a single sensor pulse gets phase 2 served, phase 1 skipped
    wait_lamp(0, 0, "p0_before_s2");
    sensor[2] = 1'b1; cyc(); sensor = '0;
    wait_lamp(0, 2, "p2_green");
    count_lamp(0, 2, 6, "p2_green_len");

    // held sensor on the main road gets exactly one extension
    sensor[0] = 1'b1;
    wait_lamp(0, 0, "p0_ext_start");
    count_lamp(0, 0, 9, "p0_ext_len");
    sensor = '0;
    count_lamp(1, 0, 2, "p0_ext_yellow");

    // pedestrian pulse during yellow
    wait_lamp(1, 0, "yel_for_walk");
    walk_req = 1'b1; cyc(); walk_req = 1'b0;
    wait_lamp(2, 0, "walk_on");
    count_lamp(2, 0, 7, "walk_len");

    // reprogram yellow mid-yellow, then zero interval
    wait_lamp(1, 0, "yel_prog");
    prog = 1'b1; prog_sel = 2'd2; prog_val = 8'd5; cyc(); prog = 1'b0;
    count_lamp(1, 0, 1, "yel_cur_unchanged");
    wait_lamp(1, 0, "yel5_start");
    count_lamp(1, 0, 5, "yel5_len");
    prog = 1'b1; prog_val = 8'd0; cyc(); prog = 1'b0;
    wait_lamp(1, 0, "yel0_start");
    count_lamp(1, 0, 1, "yel0_len");
    prog = 1'b1; prog_val = 8'd2; cyc(); prog = 1'b0;

    // flash mid-green, then release
    wait_lamp(0, 0, "green_for_flash");
    repeat (2) cyc();
    flash_mode = 1'b1;
    repeat (7) cyc();
    flash_mode = 1'b0;
    wait_lamp(0, 0, "green_after_flash");

    // asynchronous reset while walking
    walk_req = 1'b1; cyc(); walk_req = 1'b0;
    wait_lamp(2, 0, "walk_for_reset");
    repeat (2) cyc();
    reset_n = 1'b0;
    #1;
    check("async_red",   32'(red),       32'hF);
    check("async_walk",  32'(walk),      32'd0);
    check("async_green", 32'(green),     32'd0);
    check("async_phase", 32'(phase_idx), 32'd3);
    model_reset();
    @(negedge clock);
    repeat (2) cyc();
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      tick       = 1'($urandom_range(0, 1));
      sensor     = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
      walk_req   = ($urandom_range(0, 40) == 0);
      prog       = ($urandom_range(0, 60) == 0);
      prog_sel   = 2'($urandom);
      prog_val   = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 200) == 0) flash_mode = ~flash_mode;
      reset_n    = ($urandom_range(0, 800) != 0);
      cyc();
    end
    flash_mode = 1'b0; reset_n = 1'b1; sensor = '0; walk_req = 1'b0; prog = 1'b0; tick = 1'b1;
    repeat (40) cyc();

    #2;
    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
